unidade_de_despacho: RTL and testbench



---
 rtl/despacho_pkg.sv | 53 +++++
 rtl/tabela_status_registradores.sv | 45 ++++
 rtl/unidade_de_despacho.sv | 185 ++++++++++++++++++
 tb/tb_unidade_de_despacho.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/despacho_pkg.sv
// Shared constants for the dispatch unit: opcodes, functional classes,
// instruction field positions, tag encoding and FSM states.
package despacho_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned MAX_RS   = 7;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 9;
  localparam int unsigned RS_MSB = 8;
  localparam int unsigned RS_LSB = 6;
  localparam int unsigned RT_MSB = 5;
  localparam int unsigned RT_LSB = 3;

  localparam logic [TAG_W-1:0] TAG_READY = 3'd0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] CLS_ADD  = 2'd0;
  localparam logic [1:0] CLS_MUL  = 2'd1;
  localparam logic [1:0] CLS_MEM  = 2'd2;
  localparam logic [1:0] CLS_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Functional class of an opcode; NOP and HALT map to CLS_NONE.
  function automatic logic [1:0] op_class(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return CLS_ADD;
      OP_MUL, OP_DIV: return CLS_MUL;
      OP_LD,  OP_ST:  return CLS_MEM;
      default:        return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tabela_status_registradores.sv
// Register status table: producer tag per architectural register, with CDB
// bypass on the read ports and CDB clearing that yields to a same-cycle write.
module tabela_status_registradores
  import despacho_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic [REG_W-1:0] rd_addr_a,
  input  logic [REG_W-1:0] rd_addr_b,
  output logic [TAG_W-1:0] rd_tag_a_c,
  output logic [TAG_W-1:0] rd_tag_b_c,
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_addr,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag
);

  logic [NUM_REGS-1:0][TAG_W-1:0] entries;
  logic                           cdb_live;

  assign cdb_live = cdb_valid && (cdb_tag != TAG_READY);

  // A result broadcast this cycle already makes the operand available.
  always_comb begin
    rd_tag_a_c = entries[rd_addr_a];
    rd_tag_b_c = entries[rd_addr_b];
    if (cdb_live && (rd_tag_a_c == cdb_tag)) rd_tag_a_c = TAG_READY;
    if (cdb_live && (rd_tag_b_c == cdb_tag)) rd_tag_b_c = TAG_READY;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      entries <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_en && (wr_addr == REG_W'(r)))
          entries[r] <= wr_tag;
        else if (cdb_live && (entries[r] == cdb_tag))
          entries[r] <= TAG_READY;
      end
    end
  end

endmodule

// File: rtl/unidade_de_despacho.sv
// Dispatch unit: pops the instruction queue, allocates the lowest free
// reservation station of the op's class and renames operands via the RST.
module unidade_de_despacho
  import despacho_pkg::*;
#(
  parameter int unsigned NUM_RS_ADD = 3,
  parameter int unsigned NUM_RS_MUL = 2,
  parameter int unsigned NUM_RS_MEM = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Empty,
  input  logic [15:0]           Instrucao,
  output logic                  Pop,
  input  logic [NUM_RS_ADD-1:0] RS_Busy_Add,
  input  logic [NUM_RS_MUL-1:0] RS_Busy_Mul,
  input  logic [NUM_RS_MEM-1:0] RS_Busy_Mem,
  input  logic                  CDB_Valid,
  input  logic [2:0]            CDB_Tag,
  output logic                  Issue_Valid,
  output logic [1:0]            Issue_Class,
  output logic [2:0]            Issue_Slot,
  output logic [2:0]            Issue_Tag,
  output logic [3:0]            Issue_Op,
  output logic [2:0]            Issue_Rd,
  output logic [2:0]            Issue_Rs,
  output logic [2:0]            Issue_Rt,
  output logic [2:0]            Issue_Qj,
  output logic [2:0]            Issue_Qk,
  output logic                  Halted,
  output logic                  Stall
);

  state_t                    state, state_nx;
  logic [INSTR_W-1:RT_LSB]   ir;
  logic [3:0]                op;
  logic [REG_W-1:0]          rd, rs, rt;
  logic [1:0]                cls;
  logic [MAX_RS-1:0]         free;
  logic                      any_free;
  logic [TAG_W-1:0]          slot, class_base, issue_tag;
  logic [TAG_W-1:0]          qj_c, qk_c;
  logic                      pop_d, issue_d, stall_d, halted_d, ir_load, rst_we;
  logic                      unused_instr_bits;

  assign unused_instr_bits = ^Instrucao[RT_LSB-1:0];

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign rt  = ir[RT_MSB:RT_LSB];
  assign cls = op_class(op);

  // Free stations of the decoded class, then lowest free index.
  always_comb begin
    free       = '0;
    class_base = TAG_READY;
    case (cls)
      CLS_ADD: begin
        for (int unsigned i = 0; i < NUM_RS_ADD; i++) free[i] = ~RS_Busy_Add[i];
      end
      CLS_MUL: begin
        for (int unsigned i = 0; i < NUM_RS_MUL; i++) free[i] = ~RS_Busy_Mul[i];
        class_base = TAG_W'(NUM_RS_ADD);
      end
      CLS_MEM: begin
        for (int unsigned i = 0; i < NUM_RS_MEM; i++) free[i] = ~RS_Busy_Mem[i];
        class_base = TAG_W'(NUM_RS_ADD + NUM_RS_MUL);
      end
      default: ;
    endcase
  end

  always_comb begin
    any_free = 1'b0;
    slot     = '0;
    for (int i = MAX_RS - 1; i >= 0; i--) begin
      if (free[i]) begin
        any_free = 1'b1;
        slot     = TAG_W'(i);
      end
    end
  end

  assign issue_tag = class_base + slot + TAG_W'(1);

  tabela_status_registradores u_rst (
    .Clock      (Clock),
    .Reset      (Reset),
    .rd_addr_a  (rs),
    .rd_addr_b  (rt),
    .rd_tag_a_c (qj_c),
    .rd_tag_b_c (qk_c),
    .wr_en      (rst_we),
    .wr_addr    (rd),
    .wr_tag     (issue_tag),
    .cdb_valid  (CDB_Valid),
    .cdb_tag    (CDB_Tag)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (ir_load) ir <= Instrucao[INSTR_W-1:RT_LSB];
    end
  end

  // Next state plus the values the output registers take at the next edge.
  always_comb begin
    state_nx = state;
    pop_d    = 1'b0;
    issue_d  = 1'b0;
    stall_d  = 1'b0;
    halted_d = 1'b0;
    ir_load  = 1'b0;
    rst_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!Empty) begin
          state_nx = ST_POP;
          pop_d    = 1'b1;
        end
      end
      ST_POP:   state_nx = ST_FETCH;
      ST_FETCH: begin
        ir_load  = 1'b1;
        state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (op == OP_HALT) begin
          state_nx = ST_HALT;
          halted_d = 1'b1;
        end else if (cls == CLS_NONE) begin
          state_nx = ST_IDLE;
        end else if (any_free) begin
          issue_d  = 1'b1;
          rst_we   = (op != OP_ST);
          state_nx = ST_IDLE;
        end else begin
          stall_d  = 1'b1;
        end
      end
      ST_HALT:  halted_d = 1'b1;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Pop         <= 1'b0;
      Stall       <= 1'b0;
      Halted      <= 1'b0;
      Issue_Valid <= 1'b0;
      Issue_Class <= '0;
      Issue_Slot  <= '0;
      Issue_Tag   <= '0;
      Issue_Op    <= '0;
      Issue_Rd    <= '0;
      Issue_Rs    <= '0;
      Issue_Rt    <= '0;
      Issue_Qj    <= '0;
      Issue_Qk    <= '0;
    end else begin
      Pop         <= pop_d;
      Stall       <= stall_d;
      Halted      <= halted_d;
      Issue_Valid <= issue_d;
      if (issue_d) begin
        Issue_Class <= cls;
        Issue_Slot  <= slot;
        Issue_Tag   <= issue_tag;
        Issue_Op    <= op;
        Issue_Rd    <= rd;
        Issue_Rs    <= rs;
        Issue_Rt    <= rt;
        Issue_Qj    <= qj_c;
        Issue_Qk    <= (op == OP_LD) ? TAG_READY : qk_c;
      end
    end
  end

endmodule

// File: tb/tb_unidade_de_despacho.sv
// Directed bench for unidade_de_despacho with a behavioural instruction queue.
module tb_unidade_de_despacho;
  import despacho_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Empty;
  logic [15:0] Instrucao;
  logic        Pop;
  logic [2:0]  RS_Busy_Add;
  logic [1:0]  RS_Busy_Mul;
  logic [1:0]  RS_Busy_Mem;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic        Issue_Valid;
  logic [1:0]  Issue_Class;
  logic [2:0]  Issue_Slot, Issue_Tag, Issue_Rd, Issue_Rs, Issue_Rt, Issue_Qj, Issue_Qk;
  logic [3:0]  Issue_Op;
  logic        Halted;
  logic        Stall;

  int checks = 0;
  int errors = 0;

  unidade_de_despacho dut (
    .Clock(Clock), .Reset(Reset), .Empty(Empty), .Instrucao(Instrucao), .Pop(Pop),
    .RS_Busy_Add(RS_Busy_Add), .RS_Busy_Mul(RS_Busy_Mul), .RS_Busy_Mem(RS_Busy_Mem),
    .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag),
    .Issue_Valid(Issue_Valid), .Issue_Class(Issue_Class), .Issue_Slot(Issue_Slot),
    .Issue_Tag(Issue_Tag), .Issue_Op(Issue_Op), .Issue_Rd(Issue_Rd), .Issue_Rs(Issue_Rs),
    .Issue_Rt(Issue_Rt), .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
    .Halted(Halted), .Stall(Stall)
  );

  always #5 Clock = ~Clock;

  // Queue model: Instrucao is registered on the edge that sees Pop.
  logic [15:0] qmem [0:31];
  int qn = 0;
  int qh = 0;
  int pop_err = 0;
  assign Empty = (qh >= qn);

  always @(posedge Clock) begin
    if (Pop) begin
      if (qh >= qn) pop_err <= pop_err + 1;
      else begin
        Instrucao <= qmem[qh];
        qh        <= qh + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  busy_add;
    logic [1:0]  busy_mul;
    logic [1:0]  busy_mem;
    logic        exp_issue;
    logic [1:0]  cls;
    logic [2:0]  slot;
    logic [2:0]  tag;
    logic [2:0]  qj;
    logic [2:0]  qk;
  } vec_t;

  vec_t vt [10];

  function automatic logic [15:0] mk(input logic [3:0] op, input int rd, input int rs, input int rt);
    return {op, 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [15:0] instr);
    qmem[qn] = instr;
    qn = qn + 1;
  endtask

  task automatic wait_issue(input string name, output int lat);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (Issue_Valid) begin
        lat = c;
        break;
      end
    end
    chk({name, "_seen"}, 32'(Issue_Valid), 32'd1);
  endtask

  task automatic wait_stall(input string name);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (Stall) break;
    end
    chk({name, "_stall_seen"}, 32'(Stall), 32'd1);
  endtask

  logic [2:0] rst_exp [8];

  initial begin
    int lat;
    int seen;
    int nst;
    int pops_before;
    int pop_hi;
    int halt_lo;

    Reset = 1'b1; Instrucao = '0;
    RS_Busy_Add = '0; RS_Busy_Mul = '0; RS_Busy_Mem = '0;
    CDB_Valid = 1'b0; CDB_Tag = '0;

    vt[0] = '{mk(OP_ADD, 1, 2, 3), 3'b000, 2'b00, 2'b00, 1'b1, CLS_ADD, 3'd0, 3'd1, 3'd0, 3'd0};
    vt[1] = '{mk(OP_MUL, 4, 1, 1), 3'b000, 2'b00, 2'b00, 1'b1, CLS_MUL, 3'd0, 3'd4, 3'd1, 3'd1};
    vt[2] = '{mk(OP_SUB, 2, 4, 5), 3'b011, 2'b00, 2'b00, 1'b1, CLS_ADD, 3'd2, 3'd3, 3'd4, 3'd0};
    vt[3] = '{mk(OP_DIV, 6, 2, 1), 3'b000, 2'b01, 2'b00, 1'b1, CLS_MUL, 3'd1, 3'd5, 3'd3, 3'd1};
    vt[4] = '{mk(OP_LD,  7, 6, 4), 3'b000, 2'b00, 2'b00, 1'b1, CLS_MEM, 3'd0, 3'd6, 3'd5, 3'd0};
    vt[5] = '{mk(OP_ST,  0, 7, 2), 3'b000, 2'b00, 2'b01, 1'b1, CLS_MEM, 3'd1, 3'd7, 3'd6, 3'd3};
    vt[6] = '{mk(4'h6,   3, 3, 3), 3'b000, 2'b00, 2'b00, 1'b0, CLS_MEM, 3'd1, 3'd7, 3'd6, 3'd3};
    vt[7] = '{mk(OP_ADD, 0, 0, 0), 3'b000, 2'b00, 2'b00, 1'b1, CLS_ADD, 3'd0, 3'd1, 3'd0, 3'd0};
    vt[8] = '{mk(OP_ADD, 1, 1, 0), 3'b001, 2'b00, 2'b00, 1'b1, CLS_ADD, 3'd1, 3'd2, 3'd1, 3'd1};
    vt[9] = '{mk(4'hE,   5, 5, 5), 3'b000, 2'b00, 2'b00, 1'b0, CLS_ADD, 3'd1, 3'd2, 3'd1, 3'd1};
    rst_exp = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd0, 3'd5, 3'd6};

    // Reset state
    #2;
    chk("reset_pop", 32'(Pop), 0);
    chk("reset_valid", 32'(Issue_Valid), 0);
    chk("reset_halted", 32'(Halted), 0);
    chk("reset_stall", 32'(Stall), 0);
    chk("reset_fields", {Issue_Class, Issue_Slot, Issue_Tag, Issue_Op, Issue_Qj, Issue_Qk}, 0);
    step(); step();
    Reset = 1'b0;
    step();

    // Table-driven issues, one instruction at a time
    for (int i = 0; i < 10; i++) begin
      RS_Busy_Add = vt[i].busy_add;
      RS_Busy_Mul = vt[i].busy_mul;
      RS_Busy_Mem = vt[i].busy_mem;
      push(vt[i].instr);
      if (vt[i].exp_issue) begin
        wait_issue($sformatf("v%0d", i), lat);
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
        chk($sformatf("v%0d_class", i), 32'(Issue_Class), 32'(vt[i].cls));
        chk($sformatf("v%0d_slot", i), 32'(Issue_Slot), 32'(vt[i].slot));
        chk($sformatf("v%0d_tag", i), 32'(Issue_Tag), 32'(vt[i].tag));
        chk($sformatf("v%0d_qj", i), 32'(Issue_Qj), 32'(vt[i].qj));
        chk($sformatf("v%0d_qk", i), 32'(Issue_Qk), 32'(vt[i].qk));
        chk($sformatf("v%0d_fields", i), {Issue_Op, Issue_Rd, Issue_Rs, Issue_Rt}, 32'(vt[i].instr[15:3]));
        step();
        chk($sformatf("v%0d_one_cycle", i), 32'(Issue_Valid), 0);
      end else begin
        seen = 0;
        for (int c = 0; c < 8; c++) begin
          step();
          if (Issue_Valid) seen = 1;
        end
        chk($sformatf("v%0d_nop_no_issue", i), 32'(seen), 0);
        chk($sformatf("v%0d_held_tag", i), 32'(Issue_Tag), 32'(vt[i].tag));
      end
    end
    for (int r = 0; r < 8; r++)
      chk($sformatf("rst_after_table_%0d", r), 32'(dut.u_rst.entries[r]), 32'(rst_exp[r]));
    RS_Busy_Add = '0; RS_Busy_Mul = '0; RS_Busy_Mem = '0;

    // Stall while all add stations busy, then release slot 1
    RS_Busy_Add = 3'b111;
    push(mk(OP_ADD, 3, 5, 5));
    wait_stall("stall");
    nst = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (Stall && !Issue_Valid) nst++;
    end
    chk("stall_cycles", 32'(nst), 32'd5);
    RS_Busy_Add = 3'b101;
    step();
    chk("stall_release_valid", 32'(Issue_Valid), 1);
    chk("stall_release_stall", 32'(Stall), 0);
    chk("stall_release_slot", 32'(Issue_Slot), 1);
    chk("stall_release_tag", 32'(Issue_Tag), 2);
    chk("stall_release_q", {Issue_Qj, Issue_Qk}, 0);
    step();

    // Reset while an instruction is held in ISSUE
    RS_Busy_Add = 3'b111;
    push(mk(OP_ADD, 5, 0, 0));
    wait_stall("midreset");
    chk("midreset_rst3", 32'(dut.u_rst.entries[3]), 32'd2);
    push(mk(OP_ADD, 1, 2, 3));
    Reset = 1'b1;
    #1;
    chk("midreset_valid", 32'(Issue_Valid), 0);
    chk("midreset_stall", 32'(Stall), 0);
    chk("midreset_tag", 32'(Issue_Tag), 0);
    chk("midreset_rst_clear", 32'(dut.u_rst.entries), 0);
    chk("midreset_state", 32'(dut.state), 32'(ST_IDLE));
    step();
    Reset = 1'b0;
    RS_Busy_Add = '0;
    #1;
    chk("release_no_pop", 32'(Pop), 0);
    step();
    chk("release_pop", 32'(Pop), 1);
    wait_issue("after_reset", lat);
    chk("after_reset_tag", 32'(Issue_Tag), 1);
    chk("after_reset_q", {Issue_Qj, Issue_Qk}, 0);
    step();

    // CDB bypass in the issue cycle
    push(mk(OP_LD, 2, 0, 0));
    wait_issue("ld", lat);
    chk("ld_tag", 32'(Issue_Tag), 6);
    step();
    chk("rst2_is_6", 32'(dut.u_rst.entries[2]), 6);
    push(mk(OP_ADD, 5, 2, 0));
    step(); step(); step();
    chk("bypass_in_issue", 32'(dut.state), 32'(ST_ISSUE));
    CDB_Valid = 1'b1; CDB_Tag = 3'd6;
    step();
    CDB_Valid = 1'b0; CDB_Tag = 3'd0;
    chk("bypass_valid", 32'(Issue_Valid), 1);
    chk("bypass_qj", 32'(Issue_Qj), 0);
    chk("bypass_tag", 32'(Issue_Tag), 1);
    chk("bypass_rst2_cleared", 32'(dut.u_rst.entries[2]), 0);
    chk("bypass_rst5", 32'(dut.u_rst.entries[5]), 1);
    step();

    // ST does not rename; issue write beats a same-cycle CDB clear
    push(mk(OP_ST, 1, 6, 7));
    wait_issue("st", lat);
    chk("st_class_tag", {Issue_Class, Issue_Tag}, {2'd2, 3'd6});
    step();
    chk("st_rst1_unchanged", 32'(dut.u_rst.entries[1]), 1);
    RS_Busy_Add = 3'b001;
    push(mk(OP_ADD, 1, 0, 0));
    step(); step(); step();
    CDB_Valid = 1'b1; CDB_Tag = 3'd1;
    step();
    CDB_Valid = 1'b0; CDB_Tag = 3'd0;
    chk("prio_valid", 32'(Issue_Valid), 1);
    chk("prio_tag", 32'(Issue_Tag), 2);
    chk("prio_rst1_write_wins", 32'(dut.u_rst.entries[1]), 2);
    chk("prio_rst5_cleared", 32'(dut.u_rst.entries[5]), 0);
    RS_Busy_Add = '0;
    step();

    // NOP, HALT, ADD: nothing after HALT is popped
    pops_before = qh;
    push(mk(4'h7, 1, 1, 1));
    push(mk(OP_HALT, 0, 0, 0));
    push(mk(OP_ADD, 2, 3, 4));
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (Issue_Valid) seen = 1;
      if (Halted) break;
    end
    chk("halt_reached", 32'(Halted), 1);
    chk("halt_no_issue", 32'(seen), 0);
    pop_hi = 0; halt_lo = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (Pop) pop_hi++;
      if (!Halted) halt_lo++;
    end
    chk("halt_no_pop", 32'(pop_hi), 0);
    chk("halt_held", 32'(halt_lo), 0);
    chk("halt_queue_not_empty", 32'(Empty), 0);
    chk("halt_pops_consumed", 32'(qh - pops_before), 2);
    chk("pop_while_empty", 32'(pop_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
